// File: rtl/warp_scheduler.sv
// warp_scheduler: pops ready warps from warp_table and issues them to fetch; arbitrates spawn/rejoin pushes back into the table.
module warp_scheduler #(
  parameter int NUM_WARPS = 16,
  parameter int ENTRY_W = 44,
  localparam int CW = $clog2(NUM_WARPS) + 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic               wt_read_en,
  input  logic [ENTRY_W-1:0] wt_read_data,
  input  logic               wt_read_valid,
  input  logic               wt_fifo_empty,
  input  logic               wt_fifo_full,
  output logic               wt_write_en,
  output logic [ENTRY_W-1:0] wt_write_data,
  input  logic               spawn_valid,
  input  logic [ENTRY_W-1:0] spawn_data,
  output logic               spawn_ready,
  input  logic               rejoin_valid,
  input  logic [ENTRY_W-1:0] rejoin_data,
  output logic               rejoin_ready,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [31:0]        issue_pc,
  output logic [7:0]         issue_mask,
  output logic [3:0]         issue_wid,
  output logic [CW-1:0]      active_warps,
  output logic               all_done
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  localparam logic [CW-1:0] MAXW = CW'(NUM_WARPS);
  state_t state;
  logic [ENTRY_W-1:0] hold;
  logic spawned;
  logic spawn_acc, rej_acc, rej_live;
  always_comb begin
    spawn_ready = !rst && spawn_valid && !wt_fifo_full && active_warps != MAXW;
    rejoin_ready = !rst && rejoin_valid && !wt_fifo_full && !spawn_valid;
    spawn_acc = spawn_ready;
    rej_acc = rejoin_ready;
    rej_live = rej_acc && |rejoin_data[11:4];
    wt_read_en = !rst && !wt_fifo_empty && (state == IDLE || (state == HOLD && issue_ready));
  end
  assign issue_pc = hold[43:12];
  assign issue_mask = hold[11:4];
  assign issue_wid = hold[3:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hold <= '0;
      issue_valid <= 1'b0;
      active_warps <= '0;
      spawned <= 1'b0;
      all_done <= 1'b0;
      wt_write_en <= 1'b0;
      wt_write_data <= '0;
    end else begin
      wt_write_en <= spawn_acc || rej_live;
      if (spawn_acc || rej_live) wt_write_data <= spawn_acc ? spawn_data : rejoin_data;
      if (spawn_acc) active_warps <= active_warps + 1'b1;
      else if (rej_acc && !rej_live && active_warps != '0) active_warps <= active_warps - 1'b1;
      spawned <= spawned || spawn_acc;
      all_done <= !spawn_acc && spawned && active_warps == '0 && wt_fifo_empty && state == IDLE && !issue_valid;
      case (state)
        IDLE: if (!wt_fifo_empty) state <= WAIT;
        WAIT: if (wt_read_valid) begin
          hold <= wt_read_data;
          issue_valid <= 1'b1;
          state <= HOLD;
        end
        HOLD: if (issue_ready) begin
          issue_valid <= 1'b0;
          state <= wt_fifo_empty ? IDLE : WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
